// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C sensor master.
//   i2c_state_t  : bus-level FSM states
//   quarter_t    : quarter-phase index within one SCL bit period
//   i2c_cmd_t    : one latched command (address, write byte, mode)
//   BITS_FULL / BITS_ABORT : bit-times of a complete / address-NACKed transaction
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_NACK,
    ST_STOP
  } i2c_state_t;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quarter_t;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  localparam int unsigned BITS_FULL  = 20;
  localparam int unsigned BITS_ABORT = 11;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
    logic       mode;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-bit prescaler for the I2C master.
//   clock, rst_n : system clock, synchronous active-low reset
//   run          : advance the prescaler
//   clear        : hold prescaler and quarter index at zero
//   quarter      : current quarter (Q0..Q3) of the SCL bit
//   quarter_end  : last clock of the current quarter
//   bit_end      : last clock of Q3 (end of the bit)
module i2c_phase_timer
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic     clock,
  input  logic     rst_n,
  input  logic     run,
  input  logic     clear,
  output quarter_t quarter,
  output logic     quarter_end,
  output logic     bit_end
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;

  assign quarter_end = run && (presc == PRESC_LAST);
  assign bit_end     = quarter_end && (quarter == Q3);

  always_ff @(posedge clock) begin
    if (!rst_n || clear) begin
      presc   <= '0;
      quarter <= Q0;
    end else if (run) begin
      if (presc == PRESC_LAST) begin
        presc   <= '0;
        quarter <= quarter_t'(quarter + 2'd1);
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_sensor_master.sv
// Single-byte I2C initiator for sensor commands, with one pending command slot.
//   clock, rst_n            : system clock, synchronous active-low reset
//   sensorAddr_I2C/writeVal_I2C/mode_I2C/start_I2C : command inputs
//   readVal_I2C, dataRdy_I2C: last read byte and its one-cycle strobe
//   done, busy, ack_err, cmd_drop : transaction status
//   scl_oe, sda_oe          : open-drain pull-down enables; sda_in : sampled SDA
module i2c_sensor_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [6:0] sensorAddr_I2C,
  input  logic [7:0] writeVal_I2C,
  input  logic       mode_I2C,
  input  logic       start_I2C,
  output logic [7:0] readVal_I2C,
  output logic       dataRdy_I2C,
  output logic       done,
  output logic       busy,
  output logic       ack_err,
  output logic       cmd_drop,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  i2c_state_t state, state_nx;
  i2c_cmd_t   cur, pend, in_cmd;
  logic       pend_valid;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sh;
  logic [7:0] tx_byte;
  logic       tx_bit;
  logic       sda_smp;
  logic       rd_ok;
  quarter_t   quarter;
  logic       quarter_end, bit_end, sample;
  logic       launch, drop, accept;

  i2c_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clock       (clock),
    .rst_n       (rst_n),
    .run         (state != ST_IDLE),
    .clear       (state == ST_IDLE),
    .quarter     (quarter),
    .quarter_end (quarter_end),
    .bit_end     (bit_end)
  );

  assign in_cmd  = {sensorAddr_I2C, writeVal_I2C, mode_I2C};
  assign busy    = (state != ST_IDLE);
  assign sample  = quarter_end && (quarter == Q2);
  // Pending is only ever full in IDLE during the done cycle, where it launches.
  assign launch  = (state == ST_IDLE) && (start_I2C || pend_valid);
  assign drop    = start_I2C && pend_valid && (state != ST_IDLE);
  assign accept  = start_I2C && !drop;
  assign tx_byte = (state == ST_ADDR) ? {cur.addr, cur.mode} : cur.data;
  assign tx_bit  = tx_byte[~bit_cnt];

  always_ff @(posedge clock) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    scl_oe   = 1'b0;
    sda_oe   = 1'b0;
    case (state)
      ST_IDLE: if (launch) state_nx = ST_START;
      ST_START: begin
        scl_oe = (quarter == Q3);
        sda_oe = (quarter inside {Q2, Q3});
        if (bit_end) state_nx = ST_ADDR;
      end
      ST_ADDR: begin
        scl_oe = (quarter inside {Q0, Q1});
        sda_oe = !tx_bit;
        if (bit_end && bit_cnt == 3'd7) state_nx = ST_ADDR_ACK;
      end
      ST_ADDR_ACK: begin
        scl_oe = (quarter inside {Q0, Q1});
        if (bit_end) begin
          if (sda_smp)                    state_nx = ST_STOP;
          else if (cur.mode == I2C_READ)  state_nx = ST_RD_DATA;
          else                            state_nx = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        scl_oe = (quarter inside {Q0, Q1});
        sda_oe = !tx_bit;
        if (bit_end && bit_cnt == 3'd7) state_nx = ST_WR_ACK;
      end
      ST_WR_ACK: begin
        scl_oe = (quarter inside {Q0, Q1});
        if (bit_end) state_nx = ST_STOP;
      end
      ST_RD_DATA: begin
        scl_oe = (quarter inside {Q0, Q1});
        if (bit_end && bit_cnt == 3'd7) state_nx = ST_RD_NACK;
      end
      ST_RD_NACK: begin
        scl_oe = (quarter inside {Q0, Q1});
        if (bit_end) state_nx = ST_STOP;
      end
      ST_STOP: begin
        scl_oe = (quarter == Q0);
        sda_oe = (quarter != Q3);
        if (bit_end) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cur         <= '0;
      pend        <= '0;
      pend_valid  <= 1'b0;
      bit_cnt     <= '0;
      rx_sh       <= '0;
      sda_smp     <= 1'b0;
      rd_ok       <= 1'b0;
      readVal_I2C <= '0;
      dataRdy_I2C <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      cmd_drop    <= 1'b0;
    end else begin
      done        <= 1'b0;
      dataRdy_I2C <= 1'b0;
      cmd_drop    <= drop;

      if (launch) begin
        // A waiting command goes first; a concurrent strobe refills the slot.
        if (pend_valid) begin
          cur        <= pend;
          pend_valid <= start_I2C;
          if (start_I2C) pend <= in_cmd;
        end else begin
          cur <= in_cmd;
        end
        bit_cnt <= '0;
        rd_ok   <= 1'b0;
      end else if (start_I2C && !pend_valid) begin
        pend       <= in_cmd;
        pend_valid <= 1'b1;
      end

      if (accept) ack_err <= 1'b0;

      if (sample) begin
        sda_smp <= sda_in;
        if (state == ST_RD_DATA) rx_sh <= {rx_sh[6:0], sda_in};
      end

      if (bit_end) begin
        case (state)
          ST_ADDR, ST_WR_DATA: bit_cnt <= bit_cnt + 3'd1;
          ST_RD_DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rd_ok <= 1'b1;
          end
          ST_ADDR_ACK, ST_WR_ACK: if (sda_smp) ack_err <= 1'b1;
          ST_STOP: begin
            done <= 1'b1;
            if (rd_ok) begin
              readVal_I2C <= rx_sh;
              dataRdy_I2C <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
